// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands CHUNK bits per clock,
// most-significant chunk first, and stops on the first differing chunk.
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             greater,
    output logic             lesser
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic {IDLE, COMPARE} state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_q, b_q;
    logic             signed_q;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic             accept;

    assign accept = (state == IDLE) && start;

    // NOTE: the operand copies are pure data, always written on accept before they are read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
        end
    end

    // Flipping the sign bit of the top chunk maps two's-complement order onto unsigned order.
    always_comb begin
        a_sh    = a_q >> (idx * CHUNK);
        b_sh    = b_q >> (idx * CHUNK);
        a_chunk = a_sh[CHUNK-1:0];
        b_chunk = b_sh[CHUNK-1:0];
        if (signed_q && (idx == TOP_IDX)) begin
            a_chunk[CHUNK-1] = ~a_chunk[CHUNK-1];
            b_chunk[CHUNK-1] = ~b_chunk[CHUNK-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= TOP_IDX;
            busy    <= 1'b0;
            done    <= 1'b0;
            equal   <= 1'b0;
            greater <= 1'b0;
            lesser  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= TOP_IDX;
                        busy  <= 1'b1;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (a_chunk != b_chunk) begin
                        greater <= (a_chunk > b_chunk);
                        lesser  <= (a_chunk < b_chunk);
                        equal   <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (idx == '0) begin
                        equal   <= 1'b1;
                        greater <= 1'b0;
                        lesser  <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomised self-checking bench for seq_magnitude_comparator against an arithmetic
// reference model of the decision and of the number of chunks examined.
module tb_seq_magnitude_comparator;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int LIMIT  = 2 * NCHUNK + 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, equal, greater, lesser;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done),
        .equal(equal), .greater(greater), .lesser(lesser)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decision from integer arithmetic; latency from the position of the highest differing chunk.
    function automatic void model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic s, output int k, output logic [2:0] egl);
        longint xv, yv;
        bit     found;
        xv = s ? longint'($signed(x)) : longint'(x);
        yv = s ? longint'($signed(y)) : longint'(y);
        egl = {xv == yv, xv > yv, xv < yv};
        k = NCHUNK;
        found = 0;
        for (int i = NCHUNK - 1; i >= 0; i--) begin
            if (!found && (((x >> (i * CHUNK)) & 16'hF) != ((y >> (i * CHUNK)) & 16'hF))) begin
                k = NCHUNK - i;
                found = 1;
            end
        end
    endfunction

    // Caller is at a negedge; returns at the negedge where done is sampled.
    task automatic run_check(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                             input logic s, input bit scramble);
        int         k_exp, k;
        logic [2:0] egl, prev;
        bit         held;
        model(x, y, s, k_exp, egl);
        a = x; b = y; signed_mode = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        prev = {equal, greater, lesser};
        held = 1;
        k = 0;
        @(negedge clk);
        check({tag, "/busy"}, busy, 1'b1);
        while (!done && k < LIMIT) begin
            if ({equal, greater, lesser} != prev || !busy) held = 0;
            if (scramble) begin
                a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
            end
            @(negedge clk);
            k++;
        end
        check({tag, "/latency"}, k, k_exp);
        check({tag, "/done"}, done, 1'b1);
        check({tag, "/egl"}, {equal, greater, lesser}, egl);
        check({tag, "/busy_off"}, busy, 1'b0);
        check({tag, "/hold"}, held, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, dones, busys;
        logic [WIDTH-1:0] x, y;
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        #2;
        check("reset", {busy, done, equal, greater, lesser}, 5'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_check("equal", 16'h1234, 16'h1234, 1'b0, 1'b0);
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("result_held", {equal, greater, lesser}, 3'b100);

        run_check("top_unsigned", 16'h8000, 16'h7FFF, 1'b0, 1'b0);
        run_check("top_signed", 16'h8000, 16'h7FFF, 1'b1, 1'b0);
        @(negedge clk);
        run_check("mid", 16'h12A4, 16'h12B4, 1'b0, 1'b1);
        run_check("back_to_back", 16'h0001, 16'h0000, 1'b0, 1'b0);

        // start held high through the operation, dropped in the done cycle
        @(negedge clk);
        a = 16'h0F00; b = 16'h0E00; signed_mode = 1'b0; start = 1'b1;
        n = 0;
        @(negedge clk);
        while (!done && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("held_start/latency", n, 2);
        check("held_start/egl", {equal, greater, lesser}, 3'b010);
        dones = 0; busys = 0;
        repeat (LIMIT) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busys++;
        end
        check("held_start/extra_done", dones, 0);
        check("held_start/extra_busy", busys, 0);

        // asynchronous reset in the middle of a compare
        a = 16'h0000; b = 16'h0001; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 check("pre_reset/busy", busy, 1'b1);
        #1 rst = 1'b1;
        #1 check("mid_reset", {busy, done, equal, greater, lesser}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0; busys = 0;
        repeat (LIMIT) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busys++;
        end
        check("post_reset/done", dones, 0);
        check("post_reset/busy", busys, 0);
        run_check("after_reset", 16'h00F0, 16'h0F00, 1'b0, 1'b0);

        @(negedge clk);
        run_check("neg_signed", 16'hFFFE, 16'hFFFF, 1'b1, 1'b0);
        run_check("neg_unsigned", 16'hFFFE, 16'hFFFF, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            x = 16'($urandom);
            case ($urandom_range(2, 0))
                0:       y = x;
                1:       y = x ^ (16'h1 << $urandom_range(15, 0));
                default: y = 16'($urandom);
            endcase
            run_check($sformatf("rand%0d", i), x, y, 1'($urandom), 1'b1);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
